shift8_tx_seq: RTL and testbench

//  Sequencer for the 8-bit load/shift register (ld/en/dir/sd control set).

---
 rtl/shift8_pkg.sv | 19 +
 rtl/shift8_bit_timer.sv | 33 +++
 rtl/shift8_tx_seq.sv | 132 +++++++++++++
 tb/tb_shift8_tx_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift8_pkg.sv
// Shared definitions for the 8-bit load/shift register and its sequencers.
package shift8_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits per transfer.
    localparam int NBITS = 8;

    // Shift-register direction encoding on dir.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift8_bit_timer.sv
// Bit-period divider: while run is high, tick pulses once every period+1 clocks.
// clear restarts the count so the first tick lands period clocks after it.
module shift8_bit_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] per_cnt;

    assign tick = run && (per_cnt == period);

    // Count 0..period while running, wrapping on the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
        end else if (clear) begin
            per_cnt <= '0;
        end else if (run) begin
            if (tick) begin
                per_cnt <= '0;
            end else begin
                per_cnt <= per_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift8_tx_seq.sv
// Transmit sequencer for an external 8-bit load/shift register.
// One byte per valid/ready handshake: load it, then issue 8 paced shift pulses
// while ser_out presents the outgoing bit.
// Handshake: a byte is taken on a rising clock edge where valid and ready are
// both high; ready is high only in IDLE and valid is ignored otherwise.
// Optional macro SHIFT8_TX_SEQ_RX_EN: full-duplex receive (ser_in, rx_data, rx_valid).
module shift8_tx_seq
    import shift8_pkg::*;
#(
    parameter int   DIV_W = 8,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    output logic             ready,
    input  logic [7:0]       data,
    input  logic             msb_first,
    input  logic [DIV_W-1:0] div,
    input  logic             abort,
    input  logic [7:0]       q_in,
    output logic             ld,
    output logic             en,
    output logic             dir,
    output logic             sd,
    output logic [7:0]       d,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
`ifdef SHIFT8_TX_SEQ_RX_EN
    input  logic             ser_in,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
`endif
    output logic [1:0]       fsm_state
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_LOAD  = 2'(LOAD);
    localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    logic [1:0]       state;
    logic [3:0]       bit_cnt;
    logic [DIV_W-1:0] div_r;
    logic             tick;

    // Bit-period pacing; restarted in LOAD so each transfer starts clean.
    shift8_bit_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_LOAD),
        .run   (state == ST_SHIFT),
        .period(div_r),
        .tick  (tick)
    );

    // Moore outputs; an abort suppresses a shift pulse due in the same cycle.
    assign ready     = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign ld        = (state == ST_LOAD);
    assign en        = (state == ST_SHIFT) && tick && !abort;
    assign done      = (state == ST_DONE);
    assign ser_out   = (dir == DIR_RIGHT) ? q_in[0] : q_in[7];
    assign fsm_state = state;

    // Transfer sequencing and per-transfer latches (d, dir, div_r).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            d       <= '0;
            dir     <= DIR_LEFT;
            div_r   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        d     <= data;
                        dir   <= ~msb_first;
                        div_r <= div;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(NBITS - 1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT8_TX_SEQ_RX_EN
    logic [7:0] rx_data_r;

    // Incoming bits shift in behind the outgoing ones while shifting.
    assign sd       = (state == ST_SHIFT) ? ser_in : FILL;
    assign rx_valid = (state == ST_DONE);
    assign rx_data  = rx_valid ? q_in : rx_data_r;

    // Hold the received byte until the next completed transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_r <= '0;
        end else if (state == ST_DONE) begin
            rx_data_r <= q_in;
        end
    end
`else
    assign sd = FILL;
`endif

endmodule

// File: tb/tb_shift8_tx_seq.sv
// Bench for shift8_tx_seq: DUT plus an 8-bit shift register wired to its
// ld/en/dir/sd/d/q_in, a transfer-level reference model and a scoreboard.
module tb_shift8_tx_seq;

    localparam int LIMIT = 5000;

    logic       clk;
    logic       reset;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       msb_first;
    logic [7:0] div;
    logic       abort;
    logic [7:0] q;
    logic       ld, en, dir, sd, ser_out, busy, done;
    logic [7:0] d;
    logic [1:0] fsm_state;
`ifdef SHIFT8_TX_SEQ_RX_EN
    logic       ser_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    assign ser_in = ser_out;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int dones = 0;

    logic exp_q[$];

    // Reference model of the transfer in flight.
    logic       m_act = 1'b0;
    int         m_k   = 0;
    logic [7:0] m_data;
    logic       m_msb;
    logic [7:0] m_div;

    shift8_tx_seq dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .ready    (ready),
        .data     (data),
        .msb_first(msb_first),
        .div      (div),
        .abort    (abort),
        .q_in     (q),
        .ld       (ld),
        .en       (en),
        .dir      (dir),
        .sd       (sd),
        .d        (d),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done),
`ifdef SHIFT8_TX_SEQ_RX_EN
        .ser_in   (ser_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
`endif
        .fsm_state(fsm_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External shift register driven by the sequencer.
    always @(posedge clk or posedge reset) begin
        if (reset)      q <= 8'h00;
        else if (ld)    q <= d;
        else if (en)    q <= dir ? {sd, q[7:1]} : {q[6:0], sd};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor + scoreboard: model expectations from accept time and div.
    always @(negedge clk) begin
        int  p, rel, idx;
        logic busy_e, ld_e, shift_e, ab, en_e, done_e, b;
        if (reset) begin
            m_act = 1'b0;
            exp_q.delete();
        end else begin
            p       = int'(m_div) + 1;
            rel     = cyc - m_k;
            busy_e  = m_act && rel >= 1;
            ld_e    = m_act && rel == 1;
            shift_e = m_act && rel >= 2 && rel < 2 + 8 * p;
            ab      = abort && m_act && rel >= 1 && rel < 2 + 8 * p;
            en_e    = shift_e && ((rel - 2) % p == p - 1) && !ab;
            done_e  = m_act && rel == 2 + 8 * p;
            chk("ready", ready, !busy_e);
            chk("busy", busy, busy_e);
            chk("ld", ld, ld_e);
            chk("en", en, en_e);
            chk("done", done, done_e);
            if (busy_e) begin
                chk("dir", dir, !m_msb);
                chk("d", d, m_data);
            end
`ifndef SHIFT8_TX_SEQ_RX_EN
            if (shift_e) chk("sd_fill", sd, 1'b0);
`endif
            if (en) begin
                if (exp_q.size() == 0) begin
                    chk("ser_out_unexpected", 32'd0, 32'd1);
                end else begin
                    b = exp_q.pop_front();
                    chk("ser_out", ser_out, b);
                end
            end
            if (done) begin
                dones++;
                chk("bits_left_at_done", exp_q.size(), 0);
`ifdef SHIFT8_TX_SEQ_RX_EN
                chk("rx_valid", rx_valid, 1'b1);
                chk("rx_data", rx_data, m_data);
`endif
            end
            if (done_e || ab) begin
                m_act = 1'b0;
                exp_q.delete();
            end
            if (!busy_e && valid) begin
                m_act  = 1'b1;
                m_k    = cyc;
                m_data = data;
                m_msb  = msb_first;
                m_div  = div;
                for (int i = 0; i < 8; i++) begin
                    idx = m_msb ? 7 - i : i;
                    exp_q.push_back(m_data[idx]);
                end
            end
        end
    end

    // Offer a byte, return just after the accepting edge, scramble inputs.
    task automatic send(input logic [7:0] b, input logic m, input logic [7:0] dv);
        int n;
        @(posedge clk); #1;
        valid = 1'b1; data = b; msb_first = m; div = dv;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < LIMIT);
        chk("accept_timeout", ready, 1'b1);
        @(posedge clk); #1;
        valid = 1'b0;
        data = 8'($urandom); msb_first = 1'($urandom); div = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < LIMIT);
        chk("idle_timeout", ready, 1'b1);
    endtask

    task automatic pulse_abort_after(input int r);
        repeat (r) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ld"}, ld, 1'b0);
        chk({tag, "_en"}, en, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_dir"}, dir, 1'b0);
        chk({tag, "_d"}, d, 8'h00);
        chk({tag, "_sd"}, sd, 1'b0);
    endtask

    // Stimulus.
    initial begin
        int d0, dv, gap;
        reset = 1'b1; valid = 1'b0; data = 8'h00; msb_first = 1'b1;
        div = 8'h00; abort = 1'b0;
        repeat (3) @(posedge clk);
        #2 check_reset_values("rst");
        @(posedge clk); #3 reset = 1'b0;

        // Directed transfers from the timing examples.
        send(8'hA5, 1'b1, 8'd0);  wait_idle();
        send(8'hA5, 1'b0, 8'd2);  wait_idle();

        // Abort in the third bit period (div=3, period 4).
        d0 = dones;
        send(8'hC3, 1'b1, 8'd3);
        pulse_abort_after(2 + 2 * 4);
        wait_idle();
        chk("abort_no_done", dones - d0, 0);

        // Asynchronous reset mid-shift, then a clean transfer.
        send(8'hFF, 1'b1, 8'd1);
        repeat (6) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_values("midrst");
        @(posedge clk); #3 reset = 1'b0;
        send(8'h3C, 1'b1, 8'd1);  wait_idle();

        // Back-to-back with valid held high.
        d0 = dones;
        @(posedge clk); #1;
        valid = 1'b1; data = 8'h01; msb_first = 1'b1; div = 8'd0;
        @(negedge clk);
        @(posedge clk); #1;
        data = 8'h80; msb_first = 1'b0; div = 8'd1;
        wait_idle();
        @(posedge clk); #1 valid = 1'b0;
        wait_idle();
        chk("b2b_dones", dones - d0, 2);

        // Largest divider.
        send(8'h96, 1'b0, 8'hFF); wait_idle();

        // Random transfers with occasional aborts (some land in IDLE/DONE).
        for (int t = 0; t < 24; t++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            dv = ($urandom_range(0, 5) == 0) ? 7 : $urandom_range(0, 3);
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8'(dv));
            if ($urandom_range(0, 3) == 0) pulse_abort_after($urandom_range(0, 8 * (dv + 1) + 4));
            wait_idle();
        end

`ifdef SHIFT8_TX_SEQ_RX_EN
        send(8'h5A, 1'b1, 8'd1); wait_idle();
        @(negedge clk);
        chk("rx_hold", rx_data, 8'h5A);
        chk("rx_valid_low", rx_valid, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
